// File: rtl/flowid_alloc_arb.sv
// Flow-ID allocation arbiter: shares the manager's allocate port among requesters,
// merges return streams, and screens out double-frees / never-issued IDs.
package tcp_pkg;
  localparam int FLOWID_W = 8;
endpackage

module flowid_alloc_arb #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_RET  = 2,
  parameter int FLOWID_W = tcp_pkg::FLOWID_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           alloc_val,
  output logic [NUM_REQ-1:0]           alloc_rdy,
  output logic [NUM_REQ-1:0]           alloc_resp_val,
  output logic [FLOWID_W-1:0]          alloc_resp_flowid,
  input  logic [NUM_REQ-1:0]           alloc_resp_rdy,
  input  logic [NUM_RET-1:0]           ret_val,
  input  logic [NUM_RET*FLOWID_W-1:0]  ret_flowid,
  output logic [NUM_RET-1:0]           ret_rdy,
  output logic                         mgr_flowid_req,
  input  logic                         mgr_flowid_avail,
  input  logic [FLOWID_W-1:0]          mgr_flowid,
  output logic                         mgr_ret_val,
  output logic [FLOWID_W-1:0]          mgr_ret_id,
  input  logic                         mgr_ret_rdy,
  output logic [FLOWID_W:0]            outstanding,
  output logic                         err_bad_ret
);

  localparam int AIW = $clog2(NUM_REQ);
  localparam int RIW = (NUM_RET > 1) ? $clog2(NUM_RET) : 1;
  localparam int NID = 1 << FLOWID_W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [AIW-1:0]       alloc_ptr_r;
  logic [AIW-1:0]       alloc_ptr_nxt_s;
  logic [AIW-1:0]       grant_idx_s;
  logic [AIW-1:0]       resp_idx_r;
  logic [FLOWID_W-1:0]  resp_id_r;
  logic [RIW-1:0]       ret_ptr_r;
  logic [RIW-1:0]       ret_ptr_nxt_s;
  logic [RIW-1:0]       ret_idx_s;
  logic [FLOWID_W-1:0]  ret_id_s;
  logic [NID-1:0]       inuse_r;
  logic [FLOWID_W:0]    outstanding_r;
  logic                 alloc_fire_s;
  logic                 ret_any_s;
  logic                 ret_ok_s;
  logic                 ret_take_s;
  logic                 ret_fwd_s;

  // First set bit of req at or after ptr, wrapping modulo n (n <= 8).
  function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
    int   sel;
    int   idx;
    logic found;
    logic hit;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx   = (ptr + k) % n;
      hit   = (k < n) && !found && req[idx[2:0]];
      sel   = hit ? idx : sel;
      found = found | hit;
    end
    return sel;
  endfunction

  // Allocation grant: only from IDLE and only while the manager has an ID.
  always_comb begin
    grant_idx_s     = AIW'(rr_pick(8'(alloc_val), int'(alloc_ptr_r), NUM_REQ));
    alloc_ptr_nxt_s = AIW'((int'(grant_idx_s) + 1) % NUM_REQ);
    alloc_fire_s    = rst_n && (state_r == S_IDLE) && (|alloc_val) && mgr_flowid_avail;
    mgr_flowid_req  = alloc_fire_s;
    alloc_rdy       = '0;
    if (alloc_fire_s) begin
      alloc_rdy[grant_idx_s] = 1'b1;
    end else begin
      alloc_rdy = '0;
    end
  end

  // Return selection and screening against the in-use table.
  always_comb begin
    ret_idx_s     = RIW'(rr_pick(8'(ret_val), int'(ret_ptr_r), NUM_RET));
    ret_ptr_nxt_s = RIW'((int'(ret_idx_s) + 1) % NUM_RET);
    ret_id_s      = '0;
    for (int i = 0; i < NUM_RET; i++) begin
      ret_id_s = ret_id_s |
                 (ret_flowid[i*FLOWID_W +: FLOWID_W] & {FLOWID_W{int'(ret_idx_s) == i}});
    end
    ret_any_s   = rst_n && (|ret_val);
    ret_ok_s    = inuse_r[ret_id_s];
    ret_fwd_s   = ret_any_s && ret_ok_s && mgr_ret_rdy;
    // A bad return is consumed even while the manager FIFO is full.
    ret_take_s  = ret_any_s && (!ret_ok_s || mgr_ret_rdy);
    mgr_ret_val = ret_any_s && ret_ok_s;
    mgr_ret_id  = mgr_ret_val ? ret_id_s : '0;
    err_bad_ret = ret_any_s && !ret_ok_s;
    ret_rdy     = '0;
    if (ret_take_s) begin
      ret_rdy[ret_idx_s] = 1'b1;
    end else begin
      ret_rdy = '0;
    end
  end

  // Response outputs come straight from registers.
  always_comb begin
    alloc_resp_val    = '0;
    alloc_resp_flowid = resp_id_r;
    outstanding       = outstanding_r;
    if (state_r == S_RESP) begin
      alloc_resp_val[resp_idx_r] = 1'b1;
    end else begin
      alloc_resp_val = '0;
    end
  end

  // FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (alloc_fire_s) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RESP: begin
        if (alloc_resp_rdy[resp_idx_r]) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant bookkeeping: pointer and latched response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_r <= '0;
      resp_id_r   <= '0;
      resp_idx_r  <= '0;
    end else if (alloc_fire_s) begin
      alloc_ptr_r <= alloc_ptr_nxt_s;
      resp_id_r   <= mgr_flowid;
      resp_idx_r  <= grant_idx_s;
    end
  end

  // Return round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_ptr_r <= '0;
    end else if (ret_take_s) begin
      ret_ptr_r <= ret_ptr_nxt_s;
    end
  end

  // In-use table; the set is written last so it wins a same-index clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inuse_r <= '0;
    end else begin
      if (ret_fwd_s) begin
        inuse_r[ret_id_s] <= 1'b0;
      end
      if (alloc_fire_s) begin
        inuse_r[mgr_flowid] <= 1'b1;
      end
    end
  end

  // Outstanding ID count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= '0;
    end else begin
      case ({alloc_fire_s, ret_fwd_s})
        2'b10:   outstanding_r <= outstanding_r + {{FLOWID_W{1'b0}}, 1'b1};
        2'b01:   outstanding_r <= outstanding_r - {{FLOWID_W{1'b0}}, 1'b1};
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

endmodule

// File: tb/tb_flowid_alloc_arb.sv
// Bench for flowid_alloc_arb: emulated manager free list, set-based reference model,
// and queue scoreboards for allocation responses and forwarded returns.
module tb_flowid_alloc_arb;
  localparam int NR = 4;
  localparam int NT = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   alloc_val = '0;
  logic [NR-1:0]   alloc_rdy;
  logic [NR-1:0]   alloc_resp_val;
  logic [W-1:0]    alloc_resp_flowid;
  logic [NR-1:0]   alloc_resp_rdy = '0;
  logic [NT-1:0]   ret_val = '0;
  logic [NT*W-1:0] ret_flowid = '0;
  logic [NT-1:0]   ret_rdy;
  logic            mgr_flowid_req;
  logic            mgr_flowid_avail = 1'b0;
  logic [W-1:0]    mgr_flowid = '0;
  logic            mgr_ret_val;
  logic [W-1:0]    mgr_ret_id;
  logic            mgr_ret_rdy = 1'b0;
  logic [W:0]      outstanding;
  logic            err_bad_ret;

  flowid_alloc_arb #(.NUM_REQ(NR), .NUM_RET(NT), .FLOWID_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_val(alloc_val), .alloc_rdy(alloc_rdy),
    .alloc_resp_val(alloc_resp_val), .alloc_resp_flowid(alloc_resp_flowid),
    .alloc_resp_rdy(alloc_resp_rdy),
    .ret_val(ret_val), .ret_flowid(ret_flowid), .ret_rdy(ret_rdy),
    .mgr_flowid_req(mgr_flowid_req), .mgr_flowid_avail(mgr_flowid_avail),
    .mgr_flowid(mgr_flowid),
    .mgr_ret_val(mgr_ret_val), .mgr_ret_id(mgr_ret_id), .mgr_ret_rdy(mgr_ret_rdy),
    .outstanding(outstanding), .err_bad_ret(err_bad_ret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int id;
    int cyc;
  } resp_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  bit    in_reset = 1'b1;
  resp_t resp_q[$];
  int    ret_q[$];
  int    resp_idx_log[$];
  int    resp_id_log[$];
  int    ret_log[$];
  int    fl[$];
  int    hist[$];
  bit    m_inuse[256];
  int    m_aptr, m_rptr, m_out, m_idx;
  bit    m_busy;
  bit    avail_en = 1'b1;
  bit    pend_pop, pend_push;
  int    pend_id;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round-robin by the rule: scan indices ptr, ptr+1, ... modulo n.
  function automatic int rr(input int req, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    end
    return 0;
  endfunction

  task automatic model_cycle();
    int w, r, id;
    bit g, any, valid;
    chk("outstanding", outstanding, m_out);
    g = !m_busy && (alloc_val != 0) && mgr_flowid_avail;
    w = g ? rr(int'(alloc_val), m_aptr, NR) : 0;
    chk("alloc_rdy", alloc_rdy, g ? (1 << w) : 0);
    chk("mgr_flowid_req", mgr_flowid_req, g);
    any   = (ret_val != 0);
    r     = any ? rr(int'(ret_val), m_rptr, NT) : 0;
    id    = int'(ret_flowid[r*W +: W]);
    valid = any && m_inuse[id];
    chk("mgr_ret_val", mgr_ret_val, valid);
    if (valid) chk("mgr_ret_id", mgr_ret_id, id);
    chk("ret_rdy", ret_rdy, (any && (!valid || mgr_ret_rdy)) ? (1 << r) : 0);
    chk("err_bad_ret", err_bad_ret, any && !valid);
    pend_pop  = mgr_flowid_req;
    pend_push = mgr_ret_val && mgr_ret_rdy;
    pend_id   = int'(mgr_ret_id);
    if (m_busy && alloc_resp_rdy[m_idx]) m_busy = 1'b0;
    if (valid && mgr_ret_rdy) begin
      m_inuse[id] = 1'b0;
      m_out--;
      ret_q.push_back(id);
      m_rptr = (r + 1) % NT;
    end else if (any && !valid) begin
      m_rptr = (r + 1) % NT;
    end
    if (g) begin
      resp_q.push_back('{w, int'(mgr_flowid), cyc});
      m_inuse[mgr_flowid] = 1'b1;
      m_out++;
      m_aptr = (w + 1) % NR;
      m_busy = 1'b1;
      m_idx  = w;
      hist.push_back(int'(mgr_flowid));
      if (hist.size() > 16) void'(hist.pop_front());
    end
  endtask

  task automatic step();
    mgr_flowid       = (fl.size() > 0) ? W'(fl[0]) : '0;
    mgr_flowid_avail = avail_en && (fl.size() > 0);
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (pend_pop && fl.size() > 0) void'(fl.pop_front());
    if (pend_push) fl.push_back(pend_id);
  endtask

  task automatic set_idle();
    alloc_val = '0; alloc_resp_rdy = '1; ret_val = '0; ret_flowid = '0;
    mgr_ret_rdy = 1'b1; avail_en = 1'b1;
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    rst_n = 1'b0;
    alloc_val = '1; ret_val = '1; ret_flowid = {8'd7, 8'd9}; mgr_ret_rdy = 1'b1;
    mgr_flowid_avail = 1'b1; alloc_resp_rdy = '0;
    #1;
    chk("rst_alloc_rdy", alloc_rdy, 0);
    chk("rst_alloc_resp_val", alloc_resp_val, 0);
    chk("rst_resp_flowid", alloc_resp_flowid, 0);
    chk("rst_ret_rdy", ret_rdy, 0);
    chk("rst_mgr_req", mgr_flowid_req, 0);
    chk("rst_mgr_ret", {mgr_ret_val, mgr_ret_id}, 0);
    chk("rst_err", err_bad_ret, 0);
    chk("rst_outstanding", outstanding, 0);
    for (int i = 0; i < 256; i++) m_inuse[i] = 1'b0;
    m_aptr = 0; m_rptr = 0; m_out = 0; m_idx = 0; m_busy = 1'b0;
    resp_q.delete(); ret_q.delete(); resp_idx_log.delete(); resp_id_log.delete();
    ret_log.delete(); hist.delete(); fl.delete();
    for (int i = 0; i < 256; i++) fl.push_back(i);
    pend_pop = 1'b0; pend_push = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    set_idle();
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  // Response scoreboard: the pending response must be held stable until accepted.
  always @(negedge clk) begin
    #2;
    if (!in_reset) begin
      if (alloc_resp_val != 0) begin
        if (resp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL resp_unexpected: actual=%0h required=none", alloc_resp_val);
        end else begin
          chk("resp_val", alloc_resp_val, 1 << resp_q[0].idx);
          chk("resp_flowid", alloc_resp_flowid, resp_q[0].id);
          if ((alloc_resp_val & alloc_resp_rdy) != 0) begin
            resp_idx_log.push_back(resp_q[0].idx);
            resp_id_log.push_back(int'(alloc_resp_flowid));
            void'(resp_q.pop_front());
          end
        end
      end else if (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL resp_missing: actual=none required=req%0d id%0d", resp_q[0].idx, resp_q[0].id);
        void'(resp_q.pop_front());
      end
    end
  end

  // Return scoreboard: every expected forward must appear in the same cycle.
  always @(negedge clk) begin
    #2;
    if (!in_reset) begin
      if (mgr_ret_val && mgr_ret_rdy) begin
        if (ret_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ret_unexpected: actual=%0d required=none", mgr_ret_id);
        end else begin
          chk("ret_fwd_id", mgr_ret_id, ret_q[0]);
          ret_log.push_back(int'(mgr_ret_id));
          void'(ret_q.pop_front());
        end
      end else if (ret_q.size() > 0) begin
        n_tests++; n_fail++;
        $display("FAIL ret_missing: actual=none required=%0d", ret_q[0]);
        ret_q.delete();
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_idx[5];
    int rid;
    exp_idx = '{0, 1, 2, 3, 0};
    @(posedge clk); #1;
    do_reset();

    // Round-robin allocation with every response accepted at once.
    alloc_val = 4'hF;
    repeat (10) step();
    alloc_val = '0;
    step();
    chk("rr_outstanding", outstanding, 5);
    chk("rr_grant_count", resp_idx_log.size(), 5);
    for (int i = 0; i < resp_idx_log.size() && i < 5; i++) begin
      chk("rr_grant_idx", resp_idx_log[i], exp_idx[i]);
      chk("rr_grant_id", resp_id_log[i], i);
    end

    // Response back-pressure on requester 1.
    alloc_resp_rdy = '0;
    alloc_val = 4'b0010;
    step();
    alloc_val = 4'hF;
    repeat (5) step();
    alloc_resp_rdy = '1;
    alloc_val = '0;
    step();
    chk("bp_last_idx", resp_idx_log[resp_idx_log.size()-1], 1);
    chk("bp_last_id", resp_id_log[resp_id_log.size()-1], 5);

    // Manager has no ID: nothing granted until it does.
    avail_en = 1'b0;
    alloc_val = 4'hF;
    repeat (6) step();
    chk("noavail_outstanding", outstanding, 6);
    avail_en = 1'b1;
    step();
    chk("avail_grant", outstanding, 7);
    alloc_val = '0;
    step();

    // Reset while a response is pending drops it.
    alloc_val = 4'b0001;
    alloc_resp_rdy = '0;
    step(); step();
    do_reset();

    // Simultaneous returns are forwarded one per cycle, source 0 first.
    alloc_val = 4'hF;
    repeat (8) step();
    alloc_val = '0;
    step();
    chk("sim_outstanding4", outstanding, 4);
    ret_val = 2'b11;
    ret_flowid = {8'd3, 8'd2};
    step();
    chk("sim_outstanding3", outstanding, 3);
    ret_val = 2'b10;
    step();
    chk("sim_outstanding2", outstanding, 2);
    chk("sim_fwd_count", ret_log.size(), 2);
    if (ret_log.size() == 2) begin
      chk("sim_fwd_first", ret_log[0], 2);
      chk("sim_fwd_second", ret_log[1], 3);
    end

    // Double-free and never-issued ID are dropped.
    ret_val = 2'b01;
    ret_flowid = {8'd0, 8'd2};
    step();
    ret_flowid = {8'd0, 8'd200};
    step();
    ret_val = '0;
    step();
    chk("bad_ret_outstanding", outstanding, 2);
    chk("bad_ret_no_fwd", ret_log.size(), 2);

    // Manager return FIFO full: return stalls, concurrent grant completes.
    mgr_ret_rdy = 1'b0;
    ret_val = 2'b01;
    ret_flowid = {8'd0, 8'd0};
    alloc_val = 4'b0001;
    step();
    alloc_val = '0;
    step();
    chk("full_outstanding", outstanding, 3);
    mgr_ret_rdy = 1'b1;
    step();
    ret_val = '0;
    step();
    chk("full_drain_outstanding", outstanding, 2);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      alloc_val      = NR'($urandom);
      alloc_resp_rdy = ($urandom_range(0, 3) != 0) ? '1 : NR'($urandom);
      ret_val        = NT'($urandom);
      for (int s = 0; s < NT; s++) begin
        if (hist.size() > 0 && $urandom_range(0, 2) != 0) rid = hist[$urandom_range(0, hist.size()-1)];
        else rid = int'($urandom_range(0, 255));
        ret_flowid[s*W +: W] = W'(rid);
      end
      mgr_ret_rdy = ($urandom_range(0, 3) != 0);
      avail_en    = ($urandom_range(0, 4) != 0);
      step();
    end
    set_idle();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/flowid_alloc_arb.md
# flowid_alloc_arb

Arbiter and bookkeeping controller placed in front of the TCP flow-ID manager. It shares the manager's single allocate port among `NUM_REQ` requesters, such as the SYN handler and the active-open path. It merges `NUM_RET` flow-ID return streams into the manager's single return port. It tracks which IDs are outstanding so that double-frees and returns of never-issued IDs are dropped and flagged instead of corrupting the free list.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of allocation requesters, 2..8.
- `NUM_RET`, default 2: number of return sources, 1..8.
- `FLOWID_W`, default `tcp_pkg::FLOWID_W` (8): flow-ID width.

Ports:
- `clk` input, 1: the block's single clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `alloc_val` input, `NUM_REQ`: per-requester allocate request.
- `alloc_rdy` output, `NUM_REQ`: request accepted; one-hot or zero.
- `alloc_resp_val` output, `NUM_REQ`: granted flow ID valid; one-hot or zero.
- `alloc_resp_flowid` output, `FLOWID_W`: flow ID shared by all requesters.
- `alloc_resp_rdy` input, `NUM_REQ`: requester accepts the response.
- `ret_val` input, `NUM_RET`: return request.
- `ret_flowid` input, `NUM_RET*FLOWID_W`: packed returned IDs; source i uses bits `[i*FLOWID_W +: FLOWID_W]`.
- `ret_rdy` output, `NUM_RET`: return consumed; one-hot or zero.
- `mgr_flowid_req` output, 1: pop/advance pulse to the manager.
- `mgr_flowid_avail` input, 1: manager has an ID.
- `mgr_flowid` input, `FLOWID_W`: manager's combinational current ID.
- `mgr_ret_val` output, 1: return to the manager.
- `mgr_ret_id` output, `FLOWID_W`: ID being returned.
- `mgr_ret_rdy` input, 1: manager return FIFO not full.
- `outstanding` output, `FLOWID_W+1`: count of allocated, unreturned IDs.
- `err_bad_ret` output, 1: one-cycle pulse when an invalid return is dropped.

## Operation
Allocation FSM, states IDLE and RESP:
- **IDLE.** If any `alloc_val` is high and `mgr_flowid_avail` is high:
  - Pick winner w by round-robin starting at `alloc_ptr`.
  - Same cycle: `alloc_rdy[w]`=1 and `mgr_flowid_req`=1 for exactly one cycle.
  - Latch `mgr_flowid` into `resp_id_reg` and w into `resp_idx_reg`.
  - Set `inuse[mgr_flowid]`, set `alloc_ptr` to (w+1) mod `NUM_REQ`, go to RESP.
- **IDLE, manager not ready.** If `mgr_flowid_avail`=0, no request is accepted, `mgr_flowid_req`=0, and the FSM stays in IDLE.
- **RESP.** Drive `alloc_resp_val[resp_idx_reg]`=1 and `alloc_resp_flowid`=`resp_id_reg`, both held stable. When `alloc_resp_rdy[resp_idx_reg]` is high, return to IDLE. No new grant is issued in RESP.

Return path, independent of the FSM, at most one return per cycle:
- Pick source r by round-robin from `ret_ptr` among the set `ret_val` bits. Let id be the `ret_flowid` slice of r.
- **Valid return** (`inuse[id]`=1): `mgr_ret_val`=1 and `mgr_ret_id`=id. If `mgr_ret_rdy` is high, then `ret_rdy[r]`=1, clear `inuse[id]`, and advance `ret_ptr` to r+1. Otherwise stall: `ret_rdy` stays 0 and `ret_ptr` holds.
- **Invalid return** (`inuse[id]`=0): `mgr_ret_val`=0, `ret_rdy[r]`=1, `err_bad_ret`=1, advance `ret_ptr`. A dropped return does not depend on `mgr_ret_rdy`.

Bookkeeping:
- `inuse` is a register of 2^`FLOWID_W` bits.
- `outstanding` is +1 on a grant, −1 on a valid forwarded return, and unchanged when both happen in the same cycle.
- A same-cycle set and clear of the same index cannot occur, because an ID cannot be granted while it is still in use. Regardless, set takes priority.

## Timing
- **Reset.** When `rst_n`=0, asynchronously: FSM=IDLE, `alloc_ptr`=0, `ret_ptr`=0, `inuse`=0, `outstanding`=0, `resp_id_reg`=0, `resp_idx_reg`=0. All outputs read 0: `alloc_rdy`, `alloc_resp_val`, `alloc_resp_flowid`, `ret_rdy`, `mgr_flowid_req`, `mgr_ret_val`, `mgr_ret_id`, `err_bad_ret`. Reset applied mid-RESP drops the pending response.
- **Allocation latency.** Request accepted in cycle N; response valid from cycle N+1. Maximum throughput is one grant per 2 cycles.
- **Combinational paths.** `alloc_rdy`, `mgr_flowid_req`, `ret_rdy` and `mgr_ret_*` are combinational from the inputs and current state. `alloc_resp_*` are driven from registers only.
- **Return latency.** A return is forwarded in the same cycle it is presented; `inuse` is cleared and `outstanding` updated at the next clock edge.
- **Request protocol.** A requester holds `alloc_val` until it sees `alloc_rdy`. Deasserting `alloc_val` before the grant is legal and does not affect fairness.

## Test plan
- **Round-robin allocation.** Reset, then `alloc_val`=4'b1111 continuously, every response accepted immediately. Grants go to 0,1,2,3,0; flow IDs are 0,1,2,3,4, one grant every 2 cycles; `outstanding`=5.
- **Response back-pressure.** Requester 1 holds `alloc_resp_rdy` low for 5 cycles. `alloc_resp_val[1]` and the flow ID stay stable; there are no further `mgr_flowid_req` pulses until it is accepted.
- **Manager unavailable.** `mgr_flowid_avail`=0 with requests pending. `alloc_rdy`=0 and `mgr_flowid_req`=0 indefinitely; the first grant follows in the cycle `mgr_flowid_avail` rises.
- **Simultaneous returns.** After allocating IDs 0–3, both sources return IDs 2 and 3 in the same cycle. They are forwarded on consecutive cycles, source 0 first; `outstanding` goes 4→3→2.
- **Double-free.** Return ID 2 twice. The second return gets `ret_rdy`=1, `err_bad_ret` pulses, and `mgr_ret_val` stays 0. A return of never-issued ID 200 behaves the same way.
- **Manager return FIFO full.** `mgr_ret_rdy`=0 with a valid return pending. The return stalls with `ret_rdy`=0; an allocation grant issued in the same cycle still completes normally.
